// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects results from the two producers on the common data bus, execute
//   (ALU/branch) and slb (load/store buffer), and broadcasts them one at a
//   time to the consumers (rob, rs, slb). Each producer has a small circular
//   FIFO. When both producers have a result in the same cycle, neither is
//   lost. Contests are settled round-robin. The winner is broadcast from a
//   registered output port.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   rdy               global ready; when low, all state and outputs hold
//   clr               synchronous flush from rob on mispredict
//   iEX_*             execute result: en, nick (ROB tag), dt, ac (taken), j_pc
//   oEX_full          execute FIFO almost full; producer must stall
//   iSLB_*            load result: en, nick, dt
//   oSLB_full         slb FIFO almost full; producer must stall
//   oCDB_*            registered broadcast: en pulse, src (0 = EX, 1 = SLB),
//                     nick, dt, ac, j_pc (ac and j_pc are zero for slb results)

module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NICK_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iEX_en,
  input  logic [NICK_W-1:0] iEX_nick,
  input  logic [DATA_W-1:0] iEX_dt,
  input  logic              iEX_ac,
  input  logic [DATA_W-1:0] iEX_j_pc,
  output logic              oEX_full,
  input  logic              iSLB_en,
  input  logic [NICK_W-1:0] iSLB_nick,
  input  logic [DATA_W-1:0] iSLB_dt,
  output logic              oSLB_full,
  output logic              oCDB_en,
  output logic              oCDB_src,
  output logic [NICK_W-1:0] oCDB_nick,
  output logic [DATA_W-1:0] oCDB_dt,
  output logic              oCDB_ac,
  output logic [DATA_W-1:0] oCDB_j_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
    logic              ac;
    logic [DATA_W-1:0] j_pc;
  } ex_entry_t;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } slb_entry_t;

  ex_entry_t  ex_mem  [DEPTH];
  slb_entry_t slb_mem [DEPTH];

  logic [PTR_W-1:0] ex_head, ex_tail, slb_head, slb_tail;
  logic [CNT_W-1:0] ex_count, slb_count;
  // Source granted most recently: 0 = EX, 1 = SLB.
  logic             last;

  ex_entry_t  ex_in, ex_cand;
  slb_entry_t slb_in, slb_cand;
  logic       active;
  logic       ex_empty, slb_empty;
  logic       ex_has, slb_has;
  logic       grant_ex, grant_slb;
  logic       ex_push, ex_pop, slb_push, slb_pop;

  assign ex_in  = {iEX_nick, iEX_dt, iEX_ac, iEX_j_pc};
  assign slb_in = {iSLB_nick, iSLB_dt};

  // Inputs are only taken when the pipeline is advancing and not being flushed.
  assign active = rdy && !clr;

  assign ex_empty  = (ex_count == '0);
  assign slb_empty = (slb_count == '0);

  // An empty FIFO lets the incoming entry compete directly. This bypass is
  // what gives the uncontended one-cycle latency.
  assign ex_has  = !ex_empty || iEX_en;
  assign slb_has = !slb_empty || iSLB_en;

  assign ex_cand  = ex_empty  ? ex_in  : ex_mem[ex_head];
  assign slb_cand = slb_empty ? slb_in : slb_mem[slb_head];

  // Round robin: on a contest, the source that did not win last time is granted.
  always_comb begin
    grant_ex  = 1'b0;
    grant_slb = 1'b0;
    if (active) begin
      if (ex_has && slb_has) begin
        grant_ex  = last;
        grant_slb = !last;
      end else begin
        grant_ex  = ex_has;
        grant_slb = slb_has;
      end
    end
  end

  // A bypassed grant consumes the incoming entry, so that entry is not pushed.
  // A push into a completely full FIFO is a producer error and is dropped.
  assign ex_pop   = grant_ex && !ex_empty;
  assign slb_pop  = grant_slb && !slb_empty;
  assign ex_push  = active && iEX_en && !(grant_ex && ex_empty) && (ex_count != MAX_CNT);
  assign slb_push = active && iSLB_en && !(grant_slb && slb_empty) && (slb_count != MAX_CNT);

  // One entry of slack covers a producer that sees full a cycle late.
  assign oEX_full  = (ex_count >= FULL_LVL);
  assign oSLB_full = (slb_count >= FULL_LVL);

  // FIFO storage. Contents need no reset because the counts gate every read.
  always_ff @(posedge clk) begin
    if (ex_push) begin
      ex_mem[ex_tail] <= ex_in;
    end
    if (slb_push) begin
      slb_mem[slb_tail] <= slb_in;
    end
  end

  // Pointers, counts, round-robin state and the registered broadcast port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_head   <= '0;
      ex_tail   <= '0;
      ex_count  <= '0;
      slb_head  <= '0;
      slb_tail  <= '0;
      slb_count <= '0;
      last      <= 1'b1;
      oCDB_en   <= 1'b0;
      oCDB_src  <= 1'b0;
      oCDB_nick <= '0;
      oCDB_dt   <= '0;
      oCDB_ac   <= 1'b0;
      oCDB_j_pc <= '0;
    end else if (rdy) begin
      if (clr) begin
        // Flush: drop everything buffered and restore EX priority.
        ex_head   <= '0;
        ex_tail   <= '0;
        ex_count  <= '0;
        slb_head  <= '0;
        slb_tail  <= '0;
        slb_count <= '0;
        last      <= 1'b1;
        oCDB_en   <= 1'b0;
      end else begin
        if (ex_push) begin
          ex_tail <= ex_tail + PTR_W'(1);
        end
        if (ex_pop) begin
          ex_head <= ex_head + PTR_W'(1);
        end
        if (ex_push && !ex_pop) begin
          ex_count <= ex_count + CNT_W'(1);
        end else if (!ex_push && ex_pop) begin
          ex_count <= ex_count - CNT_W'(1);
        end

        if (slb_push) begin
          slb_tail <= slb_tail + PTR_W'(1);
        end
        if (slb_pop) begin
          slb_head <= slb_head + PTR_W'(1);
        end
        if (slb_push && !slb_pop) begin
          slb_count <= slb_count + CNT_W'(1);
        end else if (!slb_push && slb_pop) begin
          slb_count <= slb_count - CNT_W'(1);
        end

        if (grant_ex || grant_slb) begin
          last <= grant_slb;
        end

        // With no grant, only the valid flag drops. The data fields keep
        // their last broadcast values.
        oCDB_en <= grant_ex || grant_slb;
        if (grant_ex) begin
          oCDB_src  <= 1'b0;
          oCDB_nick <= ex_cand.nick;
          oCDB_dt   <= ex_cand.dt;
          oCDB_ac   <= ex_cand.ac;
          oCDB_j_pc <= ex_cand.j_pc;
        end else if (grant_slb) begin
          oCDB_src  <= 1'b1;
          oCDB_nick <= slb_cand.nick;
          oCDB_dt   <= slb_cand.dt;
          oCDB_ac   <= 1'b0;
          oCDB_j_pc <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter (DATA_W = 32, NICK_W = 4, DEPTH = 4).
//   It applies a table of single-cycle vectors with hand-computed outputs,
//   followed by directed multi-cycle sequences for contention, backpressure,
//   flush, stall and asynchronous reset.

module tb_cdb_arbiter;

  logic        clk, rst, rdy, clr;
  logic        iEX_en, iEX_ac;
  logic [3:0]  iEX_nick;
  logic [31:0] iEX_dt, iEX_j_pc;
  logic        oEX_full;
  logic        iSLB_en;
  logic [3:0]  iSLB_nick;
  logic [31:0] iSLB_dt;
  logic        oSLB_full;
  logic        oCDB_en, oCDB_src, oCDB_ac;
  logic [3:0]  oCDB_nick;
  logic [31:0] oCDB_dt, oCDB_j_pc;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.DATA_W(32), .NICK_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt), .iEX_ac(iEX_ac),
    .iEX_j_pc(iEX_j_pc), .oEX_full(oEX_full),
    .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
    .oSLB_full(oSLB_full),
    .oCDB_en(oCDB_en), .oCDB_src(oCDB_src), .oCDB_nick(oCDB_nick),
    .oCDB_dt(oCDB_dt), .oCDB_ac(oCDB_ac), .oCDB_j_pc(oCDB_j_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [3:0]  nick;
    logic [31:0] dt;
    logic        ac;
    logic [31:0] jpc;
  } bc_t;

  typedef struct {
    string       name;
    logic        rdy, clr;
    logic        ex_en;
    logic [3:0]  ex_nick;
    logic [31:0] ex_dt;
    logic        ex_ac;
    logic [31:0] ex_jpc;
    logic        slb_en;
    logic [3:0]  slb_nick;
    logic [31:0] slb_dt;
    logic [72:0] exp_out;
  } vec_t;

  // Broadcast log. A new broadcast is an en pulse that follows an edge with
  // rdy high, so a frozen output is not logged twice.
  bc_t  mon_q[$];
  logic rdy_q = 1'b0;

  always @(posedge clk) rdy_q <= rdy;

  always @(negedge clk) begin
    if (rst && rdy_q && oCDB_en) begin
      mon_q.push_back({oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc});
    end
  end

  function automatic logic [31:0] ex_dt_of(input logic [3:0] n);
    return 32'hE000_0000 | {28'd0, n};
  endfunction

  function automatic logic [31:0] ex_jpc_of(input logic [3:0] n);
    return 32'h0000_0400 + {26'd0, n, 2'b00};
  endfunction

  function automatic logic [31:0] slb_dt_of(input logic [3:0] n);
    return 32'h5000_0000 | {28'd0, n};
  endfunction

  function automatic bc_t exp_bc(input logic src, input logic [3:0] n);
    if (src) return {1'b1, n, slb_dt_of(n), 1'b0, 32'd0};
    return {1'b0, n, ex_dt_of(n), n[0], ex_jpc_of(n)};
  endfunction

  function automatic logic [72:0] outs();
    return {oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oEX_full, oSLB_full};
  endfunction

  function automatic logic [72:0] pack_out(input logic en, input logic src, input logic [3:0] n,
                                           input logic [31:0] dt, input logic ac, input logic [31:0] jpc,
                                           input logic exf, input logic slbf);
    return {en, src, n, dt, ac, jpc, exf, slbf};
  endfunction

  function automatic vec_t mk(input string name, input logic r, input logic c,
                              input logic ee, input logic [3:0] en_, input logic [31:0] ed,
                              input logic ea, input logic [31:0] ej,
                              input logic se, input logic [3:0] sn, input logic [31:0] sd,
                              input logic [72:0] exp_out);
    vec_t v;
    v.name = name; v.rdy = r; v.clr = c;
    v.ex_en = ee; v.ex_nick = en_; v.ex_dt = ed; v.ex_ac = ea; v.ex_jpc = ej;
    v.slb_en = se; v.slb_nick = sn; v.slb_dt = sd; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [72:0] act, input logic [72:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic idleInputs();
    rdy = 1'b1; clr = 1'b0;
    iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0; iEX_ac = 1'b0; iEX_j_pc = '0;
    iSLB_en = 1'b0; iSLB_nick = '0; iSLB_dt = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_q.delete();
  endtask

  task automatic driveEx(input logic [3:0] n);
    iEX_en = 1'b1; iEX_nick = n; iEX_dt = ex_dt_of(n); iEX_ac = n[0]; iEX_j_pc = ex_jpc_of(n);
  endtask

  task automatic driveSlb(input logic [3:0] n);
    iSLB_en = 1'b1; iSLB_nick = n; iSLB_dt = slb_dt_of(n);
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy = v.rdy; clr = v.clr;
    iEX_en = v.ex_en; iEX_nick = v.ex_nick; iEX_dt = v.ex_dt; iEX_ac = v.ex_ac; iEX_j_pc = v.ex_jpc;
    iSLB_en = v.slb_en; iSLB_nick = v.slb_nick; iSLB_dt = v.slb_dt;
    @(posedge clk);
    #1;
  endtask

  // Both producers send tags (EX 0.., SLB 8..) every cycle while not full,
  // for at most max_cyc edges. The first edge after which each full flag is
  // seen is recorded.
  task automatic runBurst(input int n_each, input int max_cyc,
                          output int first_exf, output int first_slbf);
    int ex_sent = 0;
    int slb_sent = 0;
    first_exf = -1;
    first_slbf = -1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      logic ex_go, slb_go;
      ex_go  = (ex_sent < n_each) && !oEX_full;
      slb_go = (slb_sent < n_each) && !oSLB_full;
      iEX_en = 1'b0; iSLB_en = 1'b0;
      if (ex_go) driveEx(4'(ex_sent));
      if (slb_go) driveSlb(4'(8 + slb_sent));
      @(posedge clk);
      #1;
      if (ex_go) ex_sent++;
      if (slb_go) slb_sent++;
      if (oEX_full && first_exf < 0) first_exf = cyc;
      if (oSLB_full && first_slbf < 0) first_slbf = cyc;
    end
    iEX_en = 1'b0;
    iSLB_en = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int fe, fs, bad;
    logic [72:0] frozen;

    vecs[0]  = mk("ex_single", 1, 0, 1, 4'd3, 32'h12, 1, 32'h100, 0, 4'd0, 32'h0,
                  pack_out(1, 0, 4'd3, 32'h12, 1, 32'h100, 0, 0));
    vecs[1]  = mk("idle_hold", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0,
                  pack_out(0, 0, 4'd3, 32'h12, 1, 32'h100, 0, 0));
    vecs[2]  = mk("contest_slb_wins", 1, 0, 1, 4'd1, 32'h11, 0, 32'h104, 1, 4'd2, 32'h22,
                  pack_out(1, 1, 4'd2, 32'h22, 0, 32'h0, 0, 0));
    vecs[3]  = mk("ex_from_fifo", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0,
                  pack_out(1, 0, 4'd1, 32'h11, 0, 32'h104, 0, 0));
    vecs[4]  = mk("drained", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0,
                  pack_out(0, 0, 4'd1, 32'h11, 0, 32'h104, 0, 0));
    vecs[5]  = mk("rdy_low_ignored", 0, 0, 1, 4'd5, 32'h55, 1, 32'h500, 0, 4'd0, 32'h0,
                  pack_out(0, 0, 4'd1, 32'h11, 0, 32'h104, 0, 0));
    vecs[6]  = mk("slb_single", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 4'd9, 32'h99,
                  pack_out(1, 1, 4'd9, 32'h99, 0, 32'h0, 0, 0));
    vecs[7]  = mk("clr_discards", 1, 1, 1, 4'd6, 32'h66, 1, 32'h200, 0, 4'd0, 32'h0,
                  pack_out(0, 1, 4'd9, 32'h99, 0, 32'h0, 0, 0));
    vecs[8]  = mk("after_clr_idle", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0,
                  pack_out(0, 1, 4'd9, 32'h99, 0, 32'h0, 0, 0));
    vecs[9]  = mk("contest_ex_wins", 1, 0, 1, 4'd4, 32'h44, 1, 32'h300, 1, 4'd7, 32'h77,
                  pack_out(1, 0, 4'd4, 32'h44, 1, 32'h300, 0, 0));
    vecs[10] = mk("slb_follows", 1, 0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 4'd0, 32'h0,
                  pack_out(1, 1, 4'd7, 32'h77, 0, 32'h0, 0, 0));

    // Vector table.
    doReset();
    checkOutput("reset_state", outs(), 73'd0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, outs(), vecs[i].exp_out);
    end

    // Simultaneous results right after reset: EX first, SLB immediately after.
    doReset();
    driveEx(4'd1);
    driveSlb(4'd2);
    @(posedge clk); #1;
    idleInputs();
    checkOutput("pair_first_ex", outs(),
                pack_out(1, 0, 4'd1, ex_dt_of(4'd1), 1'b1, ex_jpc_of(4'd1), 0, 0));
    @(posedge clk); #1;
    checkOutput("pair_then_slb", outs(),
                pack_out(1, 1, 4'd2, slb_dt_of(4'd2), 1'b0, 32'd0, 0, 0));

    // Sustained contention: 8 tags each, broadcasts strictly alternate.
    doReset();
    runBurst(8, 14, fe, fs);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("burst_count", 73'(mon_q.size()), 73'd16);
    bad = 0;
    for (int i = 0; i < mon_q.size() && i < 16; i++) begin
      logic s;
      s = logic'(i % 2);
      if (mon_q[i] !== exp_bc(s, s ? 4'(8 + i / 2) : 4'(i / 2))) bad++;
    end
    checkOutput("burst_order", 73'(bad), 73'd0);
    checkOutput("slb_full_edge", 73'(fs), 73'd5);
    checkOutput("ex_full_edge", 73'(fe), 73'd6);

    // Flush with three results waiting in SLB (tags 10, 11, 12).
    doReset();
    runBurst(5, 5, fe, fs);
    checkOutput("slb_full_before_clr", 73'(oSLB_full), 73'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checkOutput("clr_en_low", {71'd0, oCDB_en, oSLB_full}, 73'd0);
    repeat (6) @(posedge clk);
    #1;
    driveEx(4'd7);
    @(posedge clk); #1;
    idleInputs();
    checkOutput("post_clr_ex", outs(),
                pack_out(1, 0, 4'd7, ex_dt_of(4'd7), 1'b1, ex_jpc_of(4'd7), 0, 0));
    repeat (4) @(posedge clk);
    #1;
    bad = 0;
    foreach (mon_q[i]) begin
      if (mon_q[i].nick inside {4'd3, 4'd4, 4'd10, 4'd11, 4'd12}) bad++;
    end
    checkOutput("flushed_never_seen", 73'(bad), 73'd0);
    checkOutput("clr_bc_count", 73'(mon_q.size()), 73'd6);

    // Stall for 5 cycles while broadcasting, EX holding tags 2 and 3.
    doReset();
    runBurst(4, 4, fe, fs);
    frozen = pack_out(1, 1, 4'd9, slb_dt_of(4'd9), 1'b0, 32'd0, 0, 0);
    checkOutput("pre_stall", outs(), frozen);
    rdy = 1'b0;
    driveEx(4'd15);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall_%0d", k), outs(), frozen);
    end
    idleInputs();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("stall_bc_count", 73'(mon_q.size()), 73'd8);
    bad = 0;
    for (int i = 0; i < mon_q.size() && i < 8; i++) begin
      logic s;
      s = logic'(i % 2);
      if (mon_q[i] !== exp_bc(s, s ? 4'(8 + i / 2) : 4'(i / 2))) bad++;
    end
    checkOutput("stall_order", 73'(bad), 73'd0);

    // Asynchronous reset in the middle of a burst.
    doReset();
    runBurst(8, 6, fe, fs);
    checkOutput("pre_areset_busy", {71'd0, oCDB_en, oEX_full}, 73'd3);
    #3 rst = 1'b0;
    #1;
    checkOutput("async_reset_outs", outs(), 73'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    driveEx(4'd5);
    @(posedge clk); #1;
    idleInputs();
    checkOutput("post_reset_ex", outs(),
                pack_out(1, 0, 4'd5, ex_dt_of(4'd5), 1'b1, ex_jpc_of(4'd5), 0, 0));
    @(posedge clk); #1;
    checkOutput("post_reset_empty", {72'd0, oCDB_en}, 73'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbiter and buffer for the common data bus (CDB). It sits between the two result producers, execute (ALU/branch) and slb (load/store buffer), and the CDB consumers (rob, rs, slb). Each producer gets a small FIFO. One result is granted per cycle with round-robin priority and driven onto a single registered broadcast port, so two completions in the same cycle are never lost.

## Interface
- DATA_W, 32, data and jump-target width
- NICK_W, 4, ROB tag (nick) width
- DEPTH, 4, entries per source FIFO; power of 2, at least 2
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; when low, all state and outputs hold
- clr  in  1  synchronous flush from rob on mispredict
- iEX_en  in  1  execute result valid this cycle
- iEX_nick  in  NICK_W  ROB tag of execute result
- iEX_dt  in  DATA_W  execute result data
- iEX_ac  in  1  branch actually-taken flag
- iEX_j_pc  in  DATA_W  branch/jump target
- oEX_full  out  1  execute FIFO almost full; producer must stall
- iSLB_en  in  1  load result valid
- iSLB_nick  in  NICK_W  ROB tag of load result
- iSLB_dt  in  DATA_W  load data
- oSLB_full  out  1  slb FIFO almost full
- oCDB_en  out  1  broadcast valid, one-cycle pulse per result
- oCDB_src  out  1  0 = execute, 1 = slb
- oCDB_nick  out  NICK_W  broadcast tag
- oCDB_dt  out  DATA_W  broadcast data
- oCDB_ac  out  1  taken flag; 0 when src = slb
- oCDB_j_pc  out  DATA_W  jump target; 0 when src = slb

## Operation
- Two independent circular FIFOs, EX and SLB, each with head/tail pointers and a count of 0..DEPTH; pointers wrap modulo DEPTH.
- Candidate per source:
  - If the FIFO is non-empty, the candidate is the FIFO head.
  - If the FIFO is empty and the source's en is high, the candidate is the incoming entry (bypass).
  - Otherwise there is no candidate.
- Grant:
  - If one source has a candidate, grant it.
  - If both do, grant the source opposite to `last`.
  - `last` is a 1-bit register updated to the granted source on every grant.
- Granted candidate is registered onto the oCDB_* outputs with oCDB_en = 1. With no grant, oCDB_en = 0 and the data outputs hold their previous values.
- Push/pop per source, each cycle:
  - A granted FIFO head pops.
  - An incoming en pushes, unless it was granted via bypass.
  - Push and pop on the same cycle leave the count unchanged.
- oX_full = (count >= DEPTH-1), a combinational decode of the registered count. The one entry of slack absorbs a producer that sees full one cycle late.
- en high while count == DEPTH is a protocol violation: the entry is dropped, state is unchanged, and the bench flags an error.
- clr (with rdy high):
  - Both FIFOs are emptied and `last` returns to 1, so EX wins the first contest.
  - oCDB_en = 0 next cycle.
  - Inputs arriving in the clr cycle are discarded.
- rdy low: no push, pop, grant or output change; inputs are ignored.

## Timing
- Reset (rst = 0, asynchronous): oCDB_en = 0, oCDB_src = 0, oCDB_nick = 0, oCDB_dt = 0, oCDB_ac = 0, oCDB_j_pc = 0, both counts = 0, `last` = 1. This makes oEX_full = oSLB_full = 0. Reset mid-operation discards all buffered results.
- Uncontended latency: input sampled at edge N, broadcast visible on outputs during cycle N+1 (one cycle).
- Contested cycle: the loser is broadcast no earlier than the next cycle. Sustained throughput is one result per cycle total; under continuous contention each source gets 1/2.
- A buffered entry never waits more than 2×DEPTH cycles while rdy stays high.
- Order within a source is strict FIFO. Order across sources follows grant order only.
- Full asserts the cycle after the push that brings count to DEPTH-1. It deasserts the cycle after the pop that brings count below DEPTH-1.

## Test plan
- Single EX result (nick = 3, dt = 0x12, ac = 1, j_pc = 0x100) with both FIFOs empty -> next cycle oCDB_en = 1, src = 0, nick = 3, dt = 0x12, ac = 1, j_pc = 0x100; the cycle after, oCDB_en = 0.
- EX nick 1 and SLB nick 2 in the same cycle after reset -> EX (nick 1) broadcast first, SLB (nick 2) the following cycle; no cycle with oCDB_en = 0 in between.
- Both sources push every cycle for 8 cycles, honouring full -> broadcasts alternate EX, SLB, EX, …; every tag appears exactly once; per-source order preserved; oX_full rises when the count reaches 3.
- SLB holding 3 entries, clr pulsed -> oCDB_en = 0 the next cycle, oSLB_full = 0, none of the 3 tags is ever broadcast; a subsequent EX push is broadcast after 1 cycle.
- rdy low for 5 cycles while oCDB_en = 1 with EX holding 2 entries -> outputs frozen for the 5 cycles, no loss or duplication once rdy returns high.
- rst asserted asynchronously mid-burst -> all outputs 0 immediately without a clock edge; after release, first push broadcast with 1-cycle latency.
